fb_text_writer: RTL and testbench

FB_TEXT_WRITER -- requirements
Module: fb_text_writer

---
 rtl/fb_text_pkg.sv | 32 +++
 rtl/fb_cell_addr.sv | 19 +
 rtl/fb_text_writer.sv | 149 ++++++++++++++
 tb/tb_fb_text_writer.sv | 453 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fb_text_pkg.sv
// Shared constants, state encoding and byte-merge helper for the text-mode
// frame-buffer writer (80x60 cells, two glyphs per 16-bit word).
package fb_text_pkg;

   localparam logic [15:0] FRAME_BUFFER_START = 16'h3000;
   localparam int          COLS               = 80;
   localparam int          ROWS               = 60;
   localparam int          WORDS_PER_ROW      = 40;
   localparam int          TOTAL_WORDS        = ROWS * WORDS_PER_ROW;
   localparam logic [7:0]  BLANK              = 8'h00;

   localparam logic [7:0]  CH_BS = 8'h08;
   localparam logic [7:0]  CH_LF = 8'h0A;
   localparam logic [7:0]  CH_FF = 8'h0C;
   localparam logic [7:0]  CH_CR = 8'h0D;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_RD       = 3'd1,
      ST_WR       = 3'd2,
      ST_CLR_LINE = 3'd3,
      ST_CLR_ALL  = 3'd4
   } state_t;

   // Even columns live in the high byte, odd columns in the low byte.
   function automatic logic [15:0] merge_byte(input logic [15:0] word,
                                              input logic [7:0]  ch,
                                              input logic        low_sel);
      return low_sel ? {word[15:8], ch} : {ch, word[7:0]};
   endfunction

endpackage

// File: rtl/fb_cell_addr.sv
// Maps a (row, col) cell to its frame-buffer word address and byte lane.
// Pure combinational so the display reader can share the same mapping.
module fb_cell_addr #(
   parameter int                    ADDR_WIDTH         = 16,
   parameter logic [ADDR_WIDTH-1:0] FRAME_BUFFER_START = ADDR_WIDTH'(fb_text_pkg::FRAME_BUFFER_START)
) (
   input  logic [5:0]            i_row,
   input  logic [6:0]            i_col,
   output logic [ADDR_WIDTH-1:0] o_word_addr,
   output logic                  o_low_byte
);
   import fb_text_pkg::*;

   assign o_word_addr = FRAME_BUFFER_START
                      + ADDR_WIDTH'(i_row) * ADDR_WIDTH'(WORDS_PER_ROW)
                      + ADDR_WIDTH'(i_col[6:1]);
   assign o_low_byte  = i_col[0];

endmodule

// File: rtl/fb_text_writer.sv
// Character-stream front end for an 80x60 text frame buffer: read-modify-write
// of glyph cells, cursor handling for BS/LF/FF/CR, and line/screen clears.
//
// state       | meaning
// ------------+------------------------------------------------------------
// IDLE        | ready for a character; control codes are handled here
// RD          | cell word address presented, waiting for mem_out
// WR          | merged word written back, cursor advanced at end of cycle
// CLR_LINE    | blanking the 40 words of the row just wrapped into
// CLR_ALL     | blanking all 2400 words, cursor parked at (0,0)
module fb_text_writer #(
   parameter int                    ADDR_WIDTH         = 16,
   parameter logic [ADDR_WIDTH-1:0] FRAME_BUFFER_START = ADDR_WIDTH'(fb_text_pkg::FRAME_BUFFER_START),
   parameter logic [7:0]            BLANK              = fb_text_pkg::BLANK
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [7:0]            char_data,
   input  logic                  char_valid,
   output logic                  char_ready,
   input  logic [15:0]           mem_out,
   output logic [ADDR_WIDTH-1:0] addr_out,
   output logic                  mem_wr_en,
   output logic [15:0]           mem_wr_data,
   output logic [6:0]            cursor_col,
   output logic [5:0]            cursor_row
);
   import fb_text_pkg::*;

   state_t                r_state;
   logic [7:0]            r_char;
   logic [11:0]           r_cnt;
   logic [ADDR_WIDTH-1:0] w_cell_addr;
   logic                  w_cell_low;
   logic                  w_last_col;
   logic                  w_last_row;

   fb_cell_addr #(
      .ADDR_WIDTH         (ADDR_WIDTH),
      .FRAME_BUFFER_START (FRAME_BUFFER_START)
   ) u_cell_addr (
      .i_row       (cursor_row),
      .i_col       (cursor_col),
      .o_word_addr (w_cell_addr),
      .o_low_byte  (w_cell_low)
   );

   assign w_last_col = (cursor_col == 7'(COLS - 1));
   assign w_last_row = (cursor_row == 6'(ROWS - 1));
   assign char_ready = (r_state == ST_IDLE);

   // A row wrap always lands on row 0, so a line clear starts at the buffer base.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state     <= ST_IDLE;
         r_char      <= 8'h00;
         r_cnt       <= 12'd0;
         addr_out    <= FRAME_BUFFER_START;
         mem_wr_en   <= 1'b0;
         mem_wr_data <= 16'h0000;
         cursor_col  <= 7'd0;
         cursor_row  <= 6'd0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               mem_wr_en <= 1'b0;
               if (char_valid) begin
                  r_char <= char_data;
                  case (char_data)
                     CH_CR: cursor_col <= 7'd0;
                     CH_BS: begin
                        if (cursor_col != 7'd0)
                           cursor_col <= cursor_col - 7'd1;
                     end
                     CH_LF: begin
                        cursor_col <= 7'd0;
                        if (w_last_row) begin
                           cursor_row  <= 6'd0;
                           r_state     <= ST_CLR_LINE;
                           addr_out    <= FRAME_BUFFER_START;
                           mem_wr_en   <= 1'b1;
                           mem_wr_data <= {BLANK, BLANK};
                           r_cnt       <= 12'(WORDS_PER_ROW - 1);
                        end else begin
                           cursor_row <= cursor_row + 6'd1;
                        end
                     end
                     CH_FF: begin
                        cursor_col  <= 7'd0;
                        cursor_row  <= 6'd0;
                        r_state     <= ST_CLR_ALL;
                        addr_out    <= FRAME_BUFFER_START;
                        mem_wr_en   <= 1'b1;
                        mem_wr_data <= {BLANK, BLANK};
                        r_cnt       <= 12'(TOTAL_WORDS - 1);
                     end
                     default: begin
                        r_state  <= ST_RD;
                        addr_out <= w_cell_addr;
                     end
                  endcase
               end
            end

            ST_RD: begin
               r_state     <= ST_WR;
               mem_wr_en   <= 1'b1;
               mem_wr_data <= merge_byte(mem_out, r_char, w_cell_low);
            end

            ST_WR: begin
               r_state   <= ST_IDLE;
               mem_wr_en <= 1'b0;
               if (!w_last_col) begin
                  cursor_col <= cursor_col + 7'd1;
               end else begin
                  cursor_col <= 7'd0;
                  if (w_last_row) begin
                     cursor_row  <= 6'd0;
                     r_state     <= ST_CLR_LINE;
                     addr_out    <= FRAME_BUFFER_START;
                     mem_wr_en   <= 1'b1;
                     mem_wr_data <= {BLANK, BLANK};
                     r_cnt       <= 12'(WORDS_PER_ROW - 1);
                  end else begin
                     cursor_row <= cursor_row + 6'd1;
                  end
               end
            end

            ST_CLR_LINE, ST_CLR_ALL: begin
               if (r_cnt == 12'd0) begin
                  r_state   <= ST_IDLE;
                  mem_wr_en <= 1'b0;
               end else begin
                  r_cnt    <= r_cnt - 12'd1;
                  addr_out <= addr_out + ADDR_WIDTH'(1);
               end
            end

            default: begin
               r_state   <= ST_IDLE;
               mem_wr_en <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_fb_text_writer.sv
// Self-checking bench for fb_text_writer: a behavioural screen model (cursor
// plus an 80x60 byte grid) predicts every write, busy period and cursor move.
module tb_fb_text_writer;

   logic        clk = 1'b0;
   logic        reset;
   logic [7:0]  char_data;
   logic        char_valid;
   logic        char_ready;
   logic [15:0] mem_out;
   logic [15:0] addr_out;
   logic        mem_wr_en;
   logic [15:0] mem_wr_data;
   logic [6:0]  cursor_col;
   logic [5:0]  cursor_row;

   always #5 clk = ~clk;

   fb_text_writer #(
      .ADDR_WIDTH         (16),
      .FRAME_BUFFER_START (16'h3000),
      .BLANK              (8'h00)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .char_data   (char_data),
      .char_valid  (char_valid),
      .char_ready  (char_ready),
      .mem_out     (mem_out),
      .addr_out    (addr_out),
      .mem_wr_en   (mem_wr_en),
      .mem_wr_data (mem_wr_data),
      .cursor_col  (cursor_col),
      .cursor_row  (cursor_row)
   );

   // Frame-buffer memory owned by the bench; read data follows addr_out.
   logic [15:0] ram [0:2399];
   logic        init_req = 1'b0;
   logic        poke_en  = 1'b0;
   int          poke_idx = 0;
   logic [15:0] poke_data = 16'h0000;
   logic [31:0] wq [$];

   function automatic logic [15:0] init_word(input int i);
      logic [31:0] t;
      t = (32'(i) * 32'd40503) ^ 32'h00005A5A;
      return t[15:0];
   endfunction

   function automatic logic in_fb(input logic [15:0] a);
      return (a >= 16'h3000) && (a <= 16'h395F);
   endfunction

   assign mem_out = in_fb(addr_out) ? ram[12'(addr_out - 16'h3000)] : 16'hDEAD;

   always @(posedge clk) begin
      if (init_req) begin
         for (int i = 0; i < 2400; i++) ram[i] <= init_word(i);
      end else if (poke_en) begin
         ram[poke_idx] <= poke_data;
      end else if (mem_wr_en === 1'b1) begin
         if (in_fb(addr_out)) ram[12'(addr_out - 16'h3000)] <= mem_wr_data;
         wq.push_back({addr_out, mem_wr_data});
      end
   end

   int          checks = 0;
   int          errors = 0;

   logic [7:0]  scr [0:4799];
   int          m_col = 0;
   int          m_row = 0;
   logic [31:0] exp_wq [$];
   int          exp_busy = 0;

   function automatic logic [15:0] word_of(input int w);
      return {scr[2*w], scr[2*w+1]};
   endfunction

   task automatic model_init();
      logic [15:0] v;
      for (int i = 0; i < 2400; i++) begin
         v = init_word(i);
         scr[2*i]   = v[15:8];
         scr[2*i+1] = v[7:0];
      end
   endtask

   task automatic model_clear_row(input int r);
      int w;
      for (int c = 0; c < 40; c++) begin
         w = r * 40 + c;
         scr[2*w]   = 8'h00;
         scr[2*w+1] = 8'h00;
         exp_wq.push_back({16'(32'h3000 + w), 16'h0000});
      end
      exp_busy += 40;
   endtask

   task automatic model_char(input logic [7:0] ch);
      int idx;
      exp_wq.delete();
      exp_busy = 0;
      case (ch)
         8'h0D: m_col = 0;
         8'h08: if (m_col > 0) m_col--;
         8'h0A: begin
            m_col = 0;
            m_row++;
            if (m_row == 60) begin
               m_row = 0;
               model_clear_row(0);
            end
         end
         8'h0C: begin
            for (int w = 0; w < 2400; w++) begin
               scr[2*w]   = 8'h00;
               scr[2*w+1] = 8'h00;
               exp_wq.push_back({16'(32'h3000 + w), 16'h0000});
            end
            exp_busy = 2400;
            m_col = 0;
            m_row = 0;
         end
         default: begin
            idx = m_row * 80 + m_col;
            scr[idx] = ch;
            exp_wq.push_back({16'(32'h3000 + idx / 2), word_of(idx / 2)});
            exp_busy = 2;
            m_col++;
            if (m_col == 80) begin
               m_col = 0;
               m_row++;
               if (m_row == 60) begin
                  m_row = 0;
                  model_clear_row(0);
               end
            end
         end
      endcase
   endtask

   task automatic wait_ready();
      for (int k = 0; k < 5000; k++) begin
         @(negedge clk);
         if (char_ready === 1'b1) break;
      end
      checks++;
      if (char_ready !== 1'b1) begin
         errors++;
         $display("FAIL wait_ready: char_ready=%b required 1 within 5000 cycles", char_ready);
      end
   endtask

   task automatic poke(input int idx, input logic [15:0] val);
      @(negedge clk);
      poke_en   = 1'b1;
      poke_idx  = idx;
      poke_data = val;
      @(posedge clk);
      #1 poke_en = 1'b0;
      scr[2*idx]   = val[15:8];
      scr[2*idx+1] = val[7:0];
   endtask

   task automatic check_screen(input string name);
      int bad = 0;
      int first = -1;
      for (int w = 0; w < 2400; w++) begin
         if (ram[w] !== word_of(w)) begin
            bad++;
            if (first < 0) first = w;
         end
      end
      checks++;
      if (bad != 0) begin
         errors++;
         $display("FAIL %s: %0d words differ, first word %0d got %h required %h",
                  name, bad, first, ram[first], word_of(first));
      end
   endtask

   // Sends one character, holds junk on char_valid while busy, and checks
   // busy length, the exact write stream and the resulting cursor.
   task automatic send_char(input logic [7:0] ch);
      int  base;
      int  n = 0;
      int  bad = 0;
      int  got;
      bit  done = 0;
      model_char(ch);
      wait_ready();
      char_valid = 1'b1;
      char_data  = ch;
      base = wq.size();
      @(posedge clk);
      #1;
      if (exp_busy >= 2) char_data = 8'($urandom);
      else char_valid = 1'b0;
      for (int k = 0; k < 3000 && !done; k++) begin
         @(negedge clk);
         if (char_ready === 1'b1) done = 1;
         else n++;
         if (char_valid) begin
            @(posedge clk);
            #1 char_valid = 1'b0;
         end
      end
      char_valid = 1'b0;
      checks++;
      if (!done) begin
         errors++;
         $display("FAIL busy_timeout ch=%h: char_ready still %b after 3000 cycles", ch, char_ready);
      end
      checks++;
      if (n != exp_busy) begin
         errors++;
         $display("FAIL busy_cycles ch=%h: got %0d required %0d", ch, n, exp_busy);
      end
      got = wq.size() - base;
      checks++;
      if (got != exp_wq.size()) begin
         errors++;
         $display("FAIL write_count ch=%h: got %0d required %0d", ch, got, exp_wq.size());
      end
      for (int i = 0; i < exp_wq.size() && i < got; i++) begin
         if (wq[base + i] !== exp_wq[i]) begin
            if (bad == 0)
               $display("FAIL write_stream ch=%h [%0d]: got %h required %h",
                        ch, i, wq[base + i], exp_wq[i]);
            bad++;
         end
      end
      checks++;
      if (bad != 0) errors++;
      checks++;
      if (cursor_col !== 7'(m_col) || cursor_row !== 6'(m_row)) begin
         errors++;
         $display("FAIL cursor ch=%h: got (%0d,%0d) required (%0d,%0d)",
                  ch, cursor_col, cursor_row, m_col, m_row);
      end
   endtask

   task automatic test_reset();
      reset      = 1'b1;
      char_valid = 1'b0;
      char_data  = 8'h00;
      init_req   = 1'b1;
      @(posedge clk);
      #1 init_req = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      checks++;
      if (addr_out !== 16'h3000 || mem_wr_en !== 1'b0 || mem_wr_data !== 16'h0000) begin
         errors++;
         $display("FAIL reset_outputs: addr=%h we=%b data=%h required 3000/0/0000",
                  addr_out, mem_wr_en, mem_wr_data);
      end
      checks++;
      if (cursor_col !== 7'd0 || cursor_row !== 6'd0) begin
         errors++;
         $display("FAIL reset_cursor: got (%0d,%0d) required (0,0)", cursor_col, cursor_row);
      end
      reset = 1'b0;
      @(negedge clk);
      checks++;
      if (char_ready !== 1'b1) begin
         errors++;
         $display("FAIL reset_ready: got %b required 1", char_ready);
      end
      model_init();
      m_col = 0;
      m_row = 0;
      poke(0, 16'h1234);
   endtask

   task automatic test_first_char();
      model_char(8'h41);
      wait_ready();
      char_valid = 1'b1;
      char_data  = 8'h41;
      @(posedge clk);
      #1 char_valid = 1'b0;
      @(negedge clk);
      checks++;
      if (addr_out !== 16'h3000 || mem_wr_en !== 1'b0 || char_ready !== 1'b0) begin
         errors++;
         $display("FAIL first_rd: addr=%h we=%b rdy=%b required 3000/0/0",
                  addr_out, mem_wr_en, char_ready);
      end
      @(negedge clk);
      checks++;
      if (mem_wr_en !== 1'b1 || addr_out !== 16'h3000 || mem_wr_data !== 16'h4134) begin
         errors++;
         $display("FAIL first_wr: we=%b addr=%h data=%h required 1/3000/4134",
                  mem_wr_en, addr_out, mem_wr_data);
      end
      checks++;
      if (mem_wr_data !== exp_wq[0][15:0]) begin
         errors++;
         $display("FAIL first_wr_model: data=%h required %h", mem_wr_data, exp_wq[0][15:0]);
      end
      @(negedge clk);
      checks++;
      if (char_ready !== 1'b1 || mem_wr_en !== 1'b0) begin
         errors++;
         $display("FAIL first_ready: rdy=%b we=%b required 1/0", char_ready, mem_wr_en);
      end
      checks++;
      if (cursor_col !== 7'd1 || cursor_row !== 6'd0) begin
         errors++;
         $display("FAIL first_cursor: got (%0d,%0d) required (1,0)", cursor_col, cursor_row);
      end
   endtask

   task automatic test_control();
      send_char(8'h0D);
      send_char(8'h08);
      for (int i = 0; i < 5; i++) send_char(8'h61 + 8'(i));
      send_char(8'h0D);
      for (int i = 0; i < 3; i++) send_char(8'h0A);
      send_char(8'h0A);
      checks++;
      if (cursor_col !== 7'd0 || cursor_row !== 6'd4) begin
         errors++;
         $display("FAIL control_lf: got (%0d,%0d) required (0,4)", cursor_col, cursor_row);
      end
      check_screen("control_screen");
   endtask

   task automatic test_clear_all();
      send_char(8'h0C);
      check_screen("clear_all_screen");
   endtask

   task automatic test_cell_addr();
      send_char(8'h0A);
      send_char(8'h0A);
      send_char(8'h78);
      poke(80, 16'hAB00);
      send_char(8'h42);
      checks++;
      if (wq[wq.size() - 1] !== {16'h3050, 16'hAB42}) begin
         errors++;
         $display("FAIL cell_addr: got %h required 3050AB42", wq[wq.size() - 1]);
      end
      checks++;
      if (cursor_col !== 7'd2 || cursor_row !== 6'd2) begin
         errors++;
         $display("FAIL cell_cursor: got (%0d,%0d) required (2,2)", cursor_col, cursor_row);
      end
   endtask

   task automatic test_wrap();
      int b;
      send_char(8'h0C);
      for (int i = 0; i < 59; i++) send_char(8'h0A);
      for (int i = 0; i < 79; i++) send_char(8'($urandom_range(32'h20, 32'h7E)));
      b = wq.size();
      send_char(8'h5A);
      checks++;
      if (wq.size() - b != 41 || wq[b][31:16] !== 16'h395F || wq[b + 40] !== {16'h3027, 16'h0000}) begin
         errors++;
         $display("FAIL wrap_writes: count=%0d first=%h last=%h required 41/395F/30270000",
                  wq.size() - b, wq[b], wq[wq.size() - 1]);
      end
      check_screen("wrap_screen");
   endtask

   task automatic test_random();
      int r;
      int c;
      for (int i = 0; i < 300; i++) begin
         r = int'($urandom_range(0, 99));
         if (r < 70) begin
            c = int'($urandom_range(0, 255));
            if (c == 8 || c == 10 || c == 12 || c == 13) c = 65;
         end else if (r < 80) c = 13;
         else if (r < 90) c = 10;
         else if (r < 98) c = 8;
         else c = 12;
         send_char(8'(c));
      end
      check_screen("random_screen");
   endtask

   task automatic test_reset_mid_clear();
      bit found = 0;
      int n0;
      wait_ready();
      char_valid = 1'b1;
      char_data  = 8'h0C;
      @(posedge clk);
      #1 char_valid = 1'b0;
      for (int k = 0; k < 3000; k++) begin
         @(negedge clk);
         if (mem_wr_en === 1'b1 && addr_out === 16'h3064) begin
            found = 1;
            break;
         end
      end
      checks++;
      if (!found) begin
         errors++;
         $display("FAIL mid_clear_reach: word 100 write not seen");
      end
      reset = 1'b1;
      @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      checks++;
      if (mem_wr_en !== 1'b0 || addr_out !== 16'h3000 || mem_wr_data !== 16'h0000) begin
         errors++;
         $display("FAIL mid_clear_outputs: we=%b addr=%h data=%h required 0/3000/0000",
                  mem_wr_en, addr_out, mem_wr_data);
      end
      checks++;
      if (cursor_col !== 7'd0 || cursor_row !== 6'd0 || char_ready !== 1'b1) begin
         errors++;
         $display("FAIL mid_clear_state: cursor (%0d,%0d) rdy=%b required (0,0) 1",
                  cursor_col, cursor_row, char_ready);
      end
      n0 = wq.size();
      repeat (5) @(negedge clk);
      checks++;
      if (wq.size() != n0) begin
         errors++;
         $display("FAIL mid_clear_quiet: %0d writes after reset required 0", wq.size() - n0);
      end
      for (int w = 0; w <= 100; w++) begin
         scr[2*w]   = 8'h00;
         scr[2*w+1] = 8'h00;
      end
      m_col = 0;
      m_row = 0;
      check_screen("mid_clear_screen");
   endtask

   initial begin
      test_reset();
      test_first_char();
      test_control();
      test_clear_all();
      test_cell_addr();
      test_wrap();
      test_random();
      test_reset_mid_clear();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
